cl_pattern_gen: RTL and testbench



---
 rtl/cl_pkg.sv | 36 +++
 rtl/cl_pattern_pix.sv | 64 ++++++
 rtl/cl_pattern_gen.sv | 251 +++++++++++++++++++++++++
 tb/tb_cl_pattern_gen.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cl_pkg.sv
// Shared definitions for the Camera Link test-pattern source: pattern
// selector encodings, frame-sequencer states and the spot size.
package cl_pkg;

  localparam int SPOT_SIZE = 8;

  typedef enum logic [1:0] {
    PAT_HRAMP = 2'd0,
    PAT_VRAMP = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SPOT  = 2'd3
  } pattern_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LINE  = 3'd2,
    ST_LGAP  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_FGAP  = 3'd5
  } state_e;

  // FVAL is high from frame setup through the hold after the last line.
  function automatic logic in_frame(state_e st);
    logic res;
    case (st)
      ST_SETUP: res = 1'b1;
      ST_LINE:  res = 1'b1;
      ST_LGAP:  res = 1'b1;
      ST_HOLD:  res = 1'b1;
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cl_pattern_pix.sv
// Combinational pixel generator: one pixel value from the selected test
// pattern, the pixel column, the line number and the spot position.
module cl_pattern_pix
  import cl_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int CNT_WIDTH   = 12
) (
  input  logic [1:0]             i_pattern,
  input  logic [CNT_WIDTH-1:0]   i_col,
  input  logic [CNT_WIDTH-1:0]   i_line,
  input  logic [CNT_WIDTH-1:0]   i_spot_x,
  input  logic [CNT_WIDTH-1:0]   i_spot_y,
  output logic [PIXEL_WIDTH-1:0] o_pixel
);

  localparam logic [PIXEL_WIDTH-1:0] PIX_ON  = {PIXEL_WIDTH{1'b1}};
  localparam logic [PIXEL_WIDTH-1:0] PIX_OFF = {PIXEL_WIDTH{1'b0}};
  localparam logic [PIXEL_WIDTH-1:0] PIX_BG  = PIXEL_WIDTH'(8'h10);
  localparam logic [CNT_WIDTH:0]     SPOT_W  = (CNT_WIDTH+1)'(SPOT_SIZE);

  // One extra bit keeps spot_x+8 from wrapping, so an edge spot is clipped.
  logic [CNT_WIDTH:0] w_col_ext;
  logic [CNT_WIDTH:0] w_line_ext;
  logic [CNT_WIDTH:0] w_x_lo;
  logic [CNT_WIDTH:0] w_x_hi;
  logic [CNT_WIDTH:0] w_y_lo;
  logic [CNT_WIDTH:0] w_y_hi;
  logic               w_in_spot;

  assign w_col_ext  = {1'b0, i_col};
  assign w_line_ext = {1'b0, i_line};
  assign w_x_lo     = {1'b0, i_spot_x};
  assign w_y_lo     = {1'b0, i_spot_y};
  assign w_x_hi     = w_x_lo + SPOT_W;
  assign w_y_hi     = w_y_lo + SPOT_W;
  assign w_in_spot  = (w_col_ext >= w_x_lo) && (w_col_ext < w_x_hi) &&
                      (w_line_ext >= w_y_lo) && (w_line_ext < w_y_hi);

  // Select the pixel value for the active pattern.
  always_comb begin
    o_pixel = PIX_OFF;
    case (pattern_e'(i_pattern))
      PAT_HRAMP: o_pixel = PIXEL_WIDTH'(i_col[7:0]);
      PAT_VRAMP: o_pixel = PIXEL_WIDTH'(i_line[7:0]);
      PAT_CHECK: begin
        if (i_col[4] ^ i_line[4]) begin
          o_pixel = PIX_ON;
        end else begin
          o_pixel = PIX_OFF;
        end
      end
      PAT_SPOT: begin
        if (w_in_spot) begin
          o_pixel = PIX_ON;
        end else begin
          o_pixel = PIX_BG;
        end
      end
      default: o_pixel = PIX_OFF;
    endcase
  end

endmodule

// File: rtl/cl_pattern_gen.sv
// Camera Link base-configuration source standing in for the eye camera:
// FVAL/LVAL/DVAL framing plus two pixels per clock from test patterns.
module cl_pattern_gen
  import cl_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int FV_SETUP    = 4,
  parameter int LINE_GAP    = 16,
  parameter int FV_HOLD     = 4,
  parameter int FRAME_GAP   = 64,
  parameter int CNT_WIDTH   = 12
) (
  input  logic                   CCLK,
  input  logic                   RST_N,
  input  logic                   iENABLE,
  input  logic [1:0]             iPATTERN,
  input  logic [CNT_WIDTH-1:0]   iSPOT_X,
  input  logic [CNT_WIDTH-1:0]   iSPOT_Y,
  output logic                   oFVAL,
  output logic                   oLVAL,
  output logic                   oDVAL,
  output logic [PIXEL_WIDTH-1:0] oDATA_L,
  output logic [PIXEL_WIDTH-1:0] oDATA_R,
  output logic                   oBUSY,
  output logic                   oFRAME_DONE,
  output logic [15:0]            oFRAME_CNT
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] SETUP_LAST = CNT_WIDTH'(FV_SETUP - 1);
  localparam logic [CNT_WIDTH-1:0] PAIR_LAST  = CNT_WIDTH'(H_ACTIVE / 2 - 1);
  localparam logic [CNT_WIDTH-1:0] LGAP_LAST  = CNT_WIDTH'(LINE_GAP - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST  = CNT_WIDTH'(FV_HOLD - 1);
  localparam logic [CNT_WIDTH-1:0] FGAP_LAST  = CNT_WIDTH'(FRAME_GAP - 1);
  localparam logic [CNT_WIDTH-1:0] LINE_LAST  = CNT_WIDTH'(V_ACTIVE - 1);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;
  logic [CNT_WIDTH-1:0]   r_line;
  logic [CNT_WIDTH-1:0]   w_line_nxt;
  logic                   w_latch;

  logic [1:0]             r_pat;
  logic [CNT_WIDTH-1:0]   r_spot_x;
  logic [CNT_WIDTH-1:0]   r_spot_y;

  logic                   r_fval;
  logic                   r_lval;
  logic                   r_busy;
  logic                   r_frame_done;
  logic [PIXEL_WIDTH-1:0] r_data_l;
  logic [PIXEL_WIDTH-1:0] r_data_r;
  logic [15:0]            r_frame_cnt;

  logic                   w_in_frame;
  logic                   w_in_line;
  logic                   w_frame_end;
  logic [CNT_WIDTH-1:0]   w_col_l;
  logic [CNT_WIDTH-1:0]   w_col_r;
  logic [PIXEL_WIDTH-1:0] w_pix_l;
  logic [PIXEL_WIDTH-1:0] w_pix_r;

  // Sequencer state register.
  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, phase counter and line counter; every phase counts 0..len-1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_line_nxt  = r_line;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iENABLE) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = CNT_ZERO;
          w_line_nxt  = CNT_ZERO;
          w_latch     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_state_nxt = ST_LINE;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      ST_LINE: begin
        if (r_cnt == PAIR_LAST) begin
          w_cnt_nxt = CNT_ZERO;
          if (r_line == LINE_LAST) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_LGAP;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_LGAP: begin
        if (r_cnt == LGAP_LAST) begin
          w_state_nxt = ST_LINE;
          w_cnt_nxt   = CNT_ZERO;
          w_line_nxt  = r_line + CNT_ONE;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = ST_FGAP;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      ST_FGAP: begin
        if (r_cnt == FGAP_LAST) begin
          w_cnt_nxt = CNT_ZERO;
          if (iENABLE) begin
            w_state_nxt = ST_SETUP;
            w_line_nxt  = CNT_ZERO;
            w_latch     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
        w_line_nxt  = CNT_ZERO;
      end
    endcase
  end

  // Phase and line counters.
  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt  <= CNT_ZERO;
      r_line <= CNT_ZERO;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_line <= w_line_nxt;
    end
  end

  // Pattern and spot are captured at frame start so mid-frame changes wait.
  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pat    <= 2'd0;
      r_spot_x <= CNT_ZERO;
      r_spot_y <= CNT_ZERO;
    end else if (w_latch) begin
      r_pat    <= iPATTERN;
      r_spot_x <= iSPOT_X;
      r_spot_y <= iSPOT_Y;
    end else begin
      r_pat    <= r_pat;
      r_spot_x <= r_spot_x;
      r_spot_y <= r_spot_y;
    end
  end

  assign w_in_frame  = in_frame(r_state);
  assign w_in_line   = (r_state == ST_LINE);
  assign w_frame_end = (r_state == ST_FGAP) && (r_cnt == CNT_ZERO);
  // In LINE the phase counter is the column-pair index k.
  assign w_col_l     = {r_cnt[CNT_WIDTH-2:0], 1'b0};
  assign w_col_r     = {r_cnt[CNT_WIDTH-2:0], 1'b1};

  cl_pattern_pix #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_pix_l (
    .i_pattern (r_pat),
    .i_col     (w_col_l),
    .i_line    (r_line),
    .i_spot_x  (r_spot_x),
    .i_spot_y  (r_spot_y),
    .o_pixel   (w_pix_l)
  );

  cl_pattern_pix #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_pix_r (
    .i_pattern (r_pat),
    .i_col     (w_col_r),
    .i_line    (r_line),
    .i_spot_x  (r_spot_x),
    .i_spot_y  (r_spot_y),
    .o_pixel   (w_pix_r)
  );

  // Register framing, pixels and frame bookkeeping together so they stay aligned.
  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_fval       <= 1'b0;
      r_lval       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_data_l     <= {PIXEL_WIDTH{1'b0}};
      r_data_r     <= {PIXEL_WIDTH{1'b0}};
      r_frame_cnt  <= 16'd0;
    end else begin
      r_fval       <= w_in_frame;
      r_lval       <= w_in_line;
      r_busy       <= (r_state != ST_IDLE);
      r_frame_done <= w_frame_end;
      if (w_in_line) begin
        r_data_l <= w_pix_l;
        r_data_r <= w_pix_r;
      end else begin
        r_data_l <= {PIXEL_WIDTH{1'b0}};
        r_data_r <= {PIXEL_WIDTH{1'b0}};
      end
      if (w_frame_end) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else begin
        r_frame_cnt <= r_frame_cnt;
      end
    end
  end

  assign oFVAL       = r_fval;
  assign oLVAL       = r_lval;
  assign oDVAL       = r_lval;
  assign oDATA_L     = r_data_l;
  assign oDATA_R     = r_data_r;
  assign oBUSY       = r_busy;
  assign oFRAME_DONE = r_frame_done;
  assign oFRAME_CNT  = r_frame_cnt;

endmodule

// File: tb/tb_cl_pattern_gen.sv
// Bench for cl_pattern_gen on a tiny 8x3 frame (period 21 cycles). A
// frame-offset reference model predicts every output each cycle; scenario
// tasks add direct checks of the framing and pattern values.
module tb_cl_pattern_gen;

  localparam int PW = 8;
  localparam int HA = 8;
  localparam int VA = 3;
  localparam int FS = 2;
  localparam int LG = 1;
  localparam int FH = 2;
  localparam int FG = 3;
  localparam int CW = 12;
  localparam int PAIRS  = HA / 2;
  localparam int LPER   = PAIRS + LG;
  localparam int BODY   = VA * PAIRS + (VA - 1) * LG;
  localparam int FEND   = FS + BODY + FH;
  localparam int PERIOD = FEND + FG;

  logic          CCLK = 1'b0;
  logic          RST_N = 1'b1;
  logic          iENABLE = 1'b0;
  logic [1:0]    iPATTERN = 2'd0;
  logic [CW-1:0] iSPOT_X = 12'd0;
  logic [CW-1:0] iSPOT_Y = 12'd0;
  logic          oFVAL, oLVAL, oDVAL, oBUSY, oFRAME_DONE;
  logic [PW-1:0] oDATA_L, oDATA_R;
  logic [15:0]   oFRAME_CNT;

  int total = 0;
  int bad   = 0;

  cl_pattern_gen #(
    .PIXEL_WIDTH (PW), .H_ACTIVE (HA), .V_ACTIVE (VA), .FV_SETUP (FS),
    .LINE_GAP (LG), .FV_HOLD (FH), .FRAME_GAP (FG), .CNT_WIDTH (CW)
  ) dut (
    .CCLK (CCLK), .RST_N (RST_N), .iENABLE (iENABLE), .iPATTERN (iPATTERN),
    .iSPOT_X (iSPOT_X), .iSPOT_Y (iSPOT_Y), .oFVAL (oFVAL), .oLVAL (oLVAL),
    .oDVAL (oDVAL), .oDATA_L (oDATA_L), .oDATA_R (oDATA_R), .oBUSY (oBUSY),
    .oFRAME_DONE (oFRAME_DONE), .oFRAME_CNT (oFRAME_CNT)
  );

  always #5 CCLK = ~CCLK;

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_pix(int pat, int c, int y, int sx, int sy);
    case (pat)
      0: return 8'(c % 256);
      1: return 8'(y % 256);
      2: return ((((c / 16) % 2) ^ ((y / 16) % 2)) != 0) ? 8'hFF : 8'h00;
      default: return (c >= sx && c < sx + 8 && y >= sy && y < sy + 8) ? 8'hFF : 8'h10;
    endcase
  endfunction

  // {fval, lval, data_l, data_r} for frame offset s (0 = first FVAL cycle)
  function automatic logic [17:0] frame_out(int s, int pat, int sx, int sy);
    int b, ln, k;
    logic [7:0] l, r;
    b = s - FS;
    if (s >= FEND) return 18'd0;
    if (b < 0 || b >= BODY || (b % LPER) >= PAIRS) return {1'b1, 1'b0, 16'd0};
    ln = b / LPER;
    k  = b % LPER;
    l  = ref_pix(pat, 2 * k, ln, sx, sy);
    r  = ref_pix(pat, 2 * k + 1, ln, sx, sy);
    return {1'b1, 1'b1, l, r};
  endfunction

  bit          m_busy;
  int          m_s, m_pat, m_sx, m_sy;
  logic        e_fval, e_lval, e_busy, e_done;
  logic [7:0]  e_l, e_r;
  logic [15:0] e_cnt;

  always @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      m_busy <= 1'b0; m_s <= 0;
      e_fval <= 1'b0; e_lval <= 1'b0; e_busy <= 1'b0; e_done <= 1'b0;
      e_l <= 8'd0; e_r <= 8'd0; e_cnt <= 16'd0;
    end else begin
      if (m_busy) begin
        {e_fval, e_lval, e_l, e_r} <= frame_out(m_s, m_pat, m_sx, m_sy);
        e_done <= (m_s == FEND);
        if (m_s == FEND) e_cnt <= e_cnt + 16'd1;
      end else begin
        {e_fval, e_lval, e_l, e_r} <= 18'd0;
        e_done <= 1'b0;
      end
      e_busy <= m_busy;
      if (!m_busy) begin
        if (iENABLE) begin
          m_busy <= 1'b1; m_s <= 0;
          m_pat <= int'(iPATTERN); m_sx <= int'(iSPOT_X); m_sy <= int'(iSPOT_Y);
        end
      end else if (m_s == PERIOD - 1) begin
        m_s <= 0;
        if (iENABLE) begin
          m_pat <= int'(iPATTERN); m_sx <= int'(iSPOT_X); m_sy <= int'(iSPOT_Y);
        end else begin
          m_busy <= 1'b0;
        end
      end else begin
        m_s <= m_s + 1;
      end
    end
  end

  logic [36:0] w_got, w_exp;
  assign w_got = {oFVAL, oLVAL, oDVAL, oBUSY, oFRAME_DONE, oDATA_L, oDATA_R, oFRAME_CNT};
  assign w_exp = {e_fval, e_lval, e_lval, e_busy, e_done, e_l, e_r, e_cnt};

  // ---------------- scenarios ----------------
  task automatic test_reset;
    #2 RST_N = 1'b0;
    iENABLE = 1'b0;
    #1;
    total++;
    if ({oFVAL, oLVAL, oDVAL, oFRAME_DONE, oDATA_L, oDATA_R, oFRAME_CNT} !== 36'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", w_got);
    end
    total++;
    if (oBUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", oBUSY); end
    @(negedge CCLK); RST_N = 1'b1;
    @(negedge CCLK);
  endtask

  task automatic test_single_frame;
    int bursts, lcyc, dones, k;
    logic prev_l;
    bursts = 0; lcyc = 0; dones = 0; k = 0; prev_l = 1'b0;
    iPATTERN = 2'd0;
    iENABLE = 1'b1;
    @(negedge CCLK);
    iENABLE = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CCLK);
      total++;
      if (w_got !== w_exp) begin bad++; $display("FAIL single_cyc%0d got=%h want=%h", i, w_got, w_exp); end
      if (oLVAL && !prev_l) begin bursts++; k = 0; end
      if (oLVAL) begin
        lcyc++;
        total++;
        if ({oDATA_L, oDATA_R} !== {8'(2 * k), 8'(2 * k + 1)}) begin
          bad++; $display("FAIL hramp_pair k=%0d got=%h want=%h", k, {oDATA_L, oDATA_R}, {8'(2 * k), 8'(2 * k + 1)});
        end
        k++;
      end
      if (oFRAME_DONE) dones++;
      prev_l = oLVAL;
    end
    total++; if (bursts != 3) begin bad++; $display("FAIL single_bursts got=%0d want=3", bursts); end
    total++; if (lcyc != 12) begin bad++; $display("FAIL single_lval_cycles got=%0d want=12", lcyc); end
    total++; if (dones != 1) begin bad++; $display("FAIL single_done got=%0d want=1", dones); end
    total++; if (oFRAME_CNT !== 16'd1) begin bad++; $display("FAIL single_cnt got=%0d want=1", oFRAME_CNT); end
    total++; if ({oBUSY, oFVAL} !== 2'b00) begin bad++; $display("FAIL single_idle got=%b want=00", {oBUSY, oFVAL}); end
  endtask

  task automatic test_patterns;
    int ln, k;
    logic prev_l;
    logic [15:0] want;
    for (int p = 0; p < 2; p++) begin
      iPATTERN = (p == 0) ? 2'd1 : 2'd3;
      iSPOT_X = 12'd4; iSPOT_Y = 12'd1;
      iENABLE = 1'b1;
      @(negedge CCLK);
      iENABLE = 1'b0;
      ln = -1; k = 0; prev_l = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge CCLK);
        total++;
        if (w_got !== w_exp) begin bad++; $display("FAIL pattern%0d_cyc%0d got=%h want=%h", p, i, w_got, w_exp); end
        if (oLVAL && !prev_l) begin ln++; k = 0; end
        if (oLVAL) begin
          if (p == 0) want = {8'(ln), 8'(ln)};
          else want = {((ln >= 1 && 2 * k >= 4) ? 8'hFF : 8'h10), ((ln >= 1 && 2 * k + 1 >= 4) ? 8'hFF : 8'h10)};
          total++;
          if ({oDATA_L, oDATA_R} !== want) begin
            bad++; $display("FAIL pattern%0d line%0d k%0d got=%h want=%h", p, ln, k, {oDATA_L, oDATA_R}, want);
          end
          k++;
        end
        prev_l = oLVAL;
      end
    end
  endtask

  task automatic test_back_to_back;
    int cyc, last_rise, rises, dones;
    logic prev_f;
    RST_N = 1'b0; #1; RST_N = 1'b1;
    @(negedge CCLK);
    iPATTERN = 2'd2;
    iENABLE = 1'b1;
    cyc = 0; last_rise = -1; rises = 0; dones = 0; prev_f = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge CCLK);
      cyc++;
      total++;
      if (w_got !== w_exp) begin bad++; $display("FAIL b2b_cyc%0d got=%h want=%h", i, w_got, w_exp); end
      if (oFVAL && !prev_f) begin
        if (last_rise >= 0) begin
          total++;
          if (cyc - last_rise != PERIOD) begin
            bad++; $display("FAIL b2b_period got=%0d want=%0d", cyc - last_rise, PERIOD);
          end
        end
        last_rise = cyc; rises++;
      end
      if (oFRAME_DONE) dones++;
      prev_f = oFVAL;
      if (i == 49) iENABLE = 1'b0;
    end
    total++; if (rises != 3) begin bad++; $display("FAIL b2b_rises got=%0d want=3", rises); end
    total++; if (oFRAME_CNT !== 16'd3) begin bad++; $display("FAIL b2b_cnt got=%0d want=3", oFRAME_CNT); end
    total++; if (dones != 3) begin bad++; $display("FAIL b2b_done got=%0d want=3", dones); end
  endtask

  task automatic test_midframe_change;
    logic [15:0] cnt0;
    int k;
    logic prev_l;
    cnt0 = oFRAME_CNT; k = 0; prev_l = 1'b0;
    iPATTERN = 2'd0;
    iENABLE = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CCLK);
      total++;
      if (w_got !== w_exp) begin bad++; $display("FAIL midchg_cyc%0d got=%h want=%h", i, w_got, w_exp); end
      if (oLVAL && !prev_l) k = 0;
      if (oLVAL) begin
        total++;
        if ({oDATA_L, oDATA_R} !== {8'(2 * k), 8'(2 * k + 1)}) begin
          bad++; $display("FAIL midchg_data k=%0d got=%h want=%h", k, {oDATA_L, oDATA_R}, {8'(2 * k), 8'(2 * k + 1)});
        end
        k++;
      end
      prev_l = oLVAL;
      if (i == 8) begin
        total++;
        if (oLVAL !== 1'b1) begin bad++; $display("FAIL midchg_in_line got=%b want=1", oLVAL); end
        iPATTERN = 2'd1;
        iENABLE = 1'b0;
      end
    end
    total++; if (oFRAME_CNT !== cnt0 + 16'd1) begin bad++; $display("FAIL midchg_cnt got=%0d want=%0d", oFRAME_CNT, cnt0 + 16'd1); end
    total++; if (oBUSY !== 1'b0) begin bad++; $display("FAIL midchg_idle got=%b want=0", oBUSY); end
  endtask

  task automatic test_reset_midframe;
    bit found;
    int fcyc, lcyc;
    found = 1'b0;
    iPATTERN = 2'd0;
    iENABLE = 1'b1;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge CCLK);
      if (oLVAL === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL rstmid_reach_line got=0 want=1"); end
    #2 RST_N = 1'b0;
    #1;
    total++;
    if ({oFVAL, oLVAL, oDVAL, oBUSY, oDATA_L, oDATA_R} !== 20'd0) begin
      bad++; $display("FAIL rstmid_async got=%h want=0", {oFVAL, oLVAL, oDVAL, oBUSY, oDATA_L, oDATA_R});
    end
    @(negedge CCLK);
    RST_N = 1'b1;
    fcyc = -1; lcyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CCLK);
      total++;
      if (w_got !== w_exp) begin bad++; $display("FAIL rstmid_cyc%0d got=%h want=%h", i, w_got, w_exp); end
      if (oFVAL && fcyc < 0) fcyc = i;
      if (oLVAL && lcyc < 0) lcyc = i;
    end
    total++;
    if (fcyc < 0 || lcyc - fcyc != FS) begin
      bad++; $display("FAIL rstmid_setup got=%0d want=%0d", lcyc - fcyc, FS);
    end
    iENABLE = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CCLK);
      total++;
      if (w_got !== w_exp) begin bad++; $display("FAIL rstmid_drain%0d got=%h want=%h", i, w_got, w_exp); end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 500; i++) begin
      @(negedge CCLK);
      total++;
      if (w_got !== w_exp) begin bad++; $display("FAIL rand_cyc%0d got=%h want=%h", i, w_got, w_exp); end
      if ($urandom_range(0, 9) == 0) iENABLE = ~iENABLE;
      iPATTERN = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        iSPOT_X = 12'($urandom_range(4088, 4095));
        iSPOT_Y = 12'($urandom_range(0, 3));
      end else begin
        iSPOT_X = 12'($urandom_range(0, 9));
        iSPOT_Y = 12'($urandom_range(0, 3));
      end
    end
    iENABLE = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CCLK);
      total++;
      if (w_got !== w_exp) begin bad++; $display("FAIL rand_drain%0d got=%h want=%h", i, w_got, w_exp); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_patterns();
    test_back_to_back();
    test_midframe_change();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
